crcu_apb_master: RTL and testbench

APB requester that drives the CRCU register slave's APB port from a simple command/response stream. It accepts one register read or write command, runs the two-phase APB transfer (SETUP then ACCESS, with wait states), and returns read data and error status through a buffered response port. It sits between the CRCU configuration sequencer and the CRCU register block, and is the initiator counterpart of the CRCU APB slave.

---
 rtl/crcu_apb_pkg.sv | 31 +++
 rtl/crcu_apb_timeout_cnt.sv | 34 +++
 rtl/crcu_apb_master.sv | 140 ++++++++++++++
 tb/tb_crcu_apb_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crcu_apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crcu_apb_pkg : shared types and widths for the CRCU APB requester    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package crcu_apb_pkg;

    localparam int CRCU_APB_ADDR_W = 32;
    localparam int CRCU_APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } crcu_apb_state_e;

    typedef struct packed {
        logic                       write;
        logic [CRCU_APB_ADDR_W-1:0] addr;
        logic [CRCU_APB_DATA_W-1:0] wdata;
    } crcu_apb_cmd_t;

    typedef struct packed {
        logic [CRCU_APB_DATA_W-1:0] rdata;
        logic                       err;
        logic                       timeout;
    } crcu_apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/crcu_apb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crcu_apb_timeout_cnt : ACCESS-phase wait-state counter, flags expiry |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crcu_apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;

    // Holds at the limit so a late PREADY cannot wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule
`default_nettype wire

// File: rtl/crcu_apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crcu_apb_master : command/response to APB requester (one in flight). |
// | Optional ACCESS timeout when CRCU_APB_TIMEOUT_EN is defined. Rev 1.0 |
// +----------------------------------------------------------------------+
module crcu_apb_master
    import crcu_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CRCU_CLK,
    input  logic        CRCU_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA
);

    crcu_apb_state_e r_state, w_next;
    crcu_apb_cmd_t   r_cmd;
    crcu_apb_rsp_t   r_rsp;
    logic            r_ready_en;
    logic            w_accept, w_done, w_tmo, w_expired;
    logic [31:0]     w_addr_aligned;

    assign w_addr_aligned = cmd_addr & 32'hFFFF_FFFC;

`ifdef CRCU_APB_TIMEOUT_EN
    crcu_apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (CRCU_CLK),
        .rst     (CRCU_RST),
        .clear   (r_state == SETUP),
        .enable  ((r_state == ACCESS) && !PREADY),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = r_ready_en;
                if (cmd_valid && r_ready_en) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP: begin
                PSEL   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // A completing PREADY takes priority over an expiring counter.
                if (PREADY) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if (w_expired) begin
                    w_tmo  = 1'b1;
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // cmd_ready stays low while reset is held and rises on the first edge after release.
    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            r_ready_en <= 1'b0;
            r_cmd      <= '0;
            r_rsp      <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_cmd.write <= cmd_write;
                r_cmd.addr  <= w_addr_aligned;
                r_cmd.wdata <= cmd_write ? cmd_wdata : 32'h0;
            end
            if (w_done) begin
                r_rsp.rdata   <= r_cmd.write ? 32'h0 : PRDATA;
                r_rsp.err     <= PSLVERR;
                r_rsp.timeout <= 1'b0;
            end else if (w_tmo) begin
                r_rsp.rdata   <= 32'h0;
                r_rsp.err     <= 1'b1;
                r_rsp.timeout <= 1'b1;
            end
        end
    end

    assign PWRITE      = r_cmd.write;
    assign PADDR       = r_cmd.addr;
    assign PWDATA      = r_cmd.wdata;
    assign rsp_rdata   = r_rsp.rdata;
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;

endmodule
`default_nettype wire

// File: tb/tb_crcu_apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crcu_apb_master : directed vector bench with an APB slave model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_crcu_apb_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    crcu_apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .CRCU_CLK   (clk),
        .CRCU_RST   (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .PRDATA     (PRDATA)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;     // ACCESS cycles with PREADY low; -1 = never ready
        logic [31:0] prdata;
        logic        slverr;
        int          stall;     // cycles rsp_ready is held low after rsp_valid
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_tmo;
        int          e_nacc;    // expected number of ACCESS cycles
        int          e_lat;     // accept cycle to first rsp_valid cycle
    } vec_t;

    function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] wdata, int waits,
                                logic [31:0] prdata, logic slverr, int stall,
                                logic [31:0] e_paddr, logic [31:0] e_pwdata,
                                logic [31:0] e_rdata, logic e_err, logic e_tmo,
                                int e_nacc, int e_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits;
        v.prdata = prdata; v.slverr = slverr; v.stall = stall;
        v.e_paddr = e_paddr; v.e_pwdata = e_pwdata; v.e_rdata = e_rdata;
        v.e_err = e_err; v.e_tmo = e_tmo; v.e_nacc = e_nacc; v.e_lat = e_lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic do_xfer(input string tag, input vec_t v);
        int  acc, n_acc, n_sel, n_en;
        bit  got, bad_ctl, bad_busy, bad_hold;
        logic [31:0] h_rdata;
        logic        h_err, h_tmo;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hBAD0BAD0;
        chk({tag, ".cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = $urandom; cmd_wdata = $urandom;
        n_acc = 0; n_sel = 0; n_en = 0; got = 0; bad_ctl = 0; bad_busy = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (rsp_valid) begin
                got = 1;
            end else begin
                if (cmd_ready) bad_busy = 1;
                if (PSEL) n_sel++;
                if (PENABLE) n_en++;
                if (PSEL && (PADDR !== v.e_paddr || PWDATA !== v.e_pwdata || PWRITE !== v.wr))
                    bad_ctl = 1;
                if (PSEL && PENABLE) begin
                    n_acc++;
                    if (v.waits >= 0 && n_acc > v.waits) begin
                        PREADY = 1'b1; PSLVERR = v.slverr; PRDATA = v.prdata;
                    end else begin
                        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hDEAD0000 | n_acc;
                    end
                end else begin
                    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hBAD0BAD0;
                end
                @(negedge clk);
            end
        end
        chk({tag, ".rsp_seen"}, {31'b0, got}, 32'd1);
        chk({tag, ".latency"}, cyc - acc, v.e_lat);
        chk({tag, ".psel_cycles"}, n_sel, v.e_nacc + 1);
        chk({tag, ".penable_cycles"}, n_en, v.e_nacc);
        chk({tag, ".apb_addr_data_stable"}, {31'b0, bad_ctl}, 32'd0);
        chk({tag, ".busy_cmd_ready_low"}, {31'b0, bad_busy}, 32'd0);
        chk({tag, ".resp_psel_low"}, {30'b0, PSEL, PENABLE}, 32'd0);
        chk({tag, ".rdata"}, rsp_rdata, v.e_rdata);
        chk({tag, ".err_tmo"}, {30'b0, rsp_err, rsp_timeout}, {30'b0, v.e_err, v.e_tmo});
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'h5555AAAA;
        h_rdata = rsp_rdata; h_err = rsp_err; h_tmo = rsp_timeout; bad_hold = 0;
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || PSEL || rsp_rdata !== h_rdata ||
                rsp_err !== h_err || rsp_timeout !== h_tmo)
                bad_hold = 1;
        end
        if (v.stall > 0) chk({tag, ".stall_hold"}, {31'b0, bad_hold}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".back_to_idle"}, {30'b0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    vec_t tbl[5];
    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_seen[3];
    int          b2b_acc[3];

    initial begin
        // write 0x10: 1 ACCESS cycle; read 0x14 with 3 waits; slave error with backpressure;
        // unaligned read with error keeps PRDATA; top-of-map read.
        tbl[0] = mk(1'b1, 32'h0000_0010, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 0,
                    32'h0000_0010, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 1, 3);
        tbl[1] = mk(1'b0, 32'h0000_0014, 32'h1234_5678, 3, 32'h0000_0007, 1'b0, 0,
                    32'h0000_0014, 32'h0, 32'h0000_0007, 1'b0, 1'b0, 4, 6);
        tbl[2] = mk(1'b1, 32'h0000_0020, 32'hCAFE_0003, 1, 32'h0000_0055, 1'b1, 5,
                    32'h0000_0020, 32'hCAFE_0003, 32'h0, 1'b1, 1'b0, 2, 4);
        tbl[3] = mk(1'b0, 32'h0000_0107, 32'hFFFF_FFFF, 0, 32'h89AB_CDEF, 1'b1, 2,
                    32'h0000_0104, 32'h0, 32'h89AB_CDEF, 1'b1, 1'b0, 1, 3);
        tbl[4] = mk(1'b0, 32'hFFFF_FFFF, 32'h0, 2, 32'h0000_0001, 1'b0, 1,
                    32'hFFFF_FFFC, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 3, 5);

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
        #1;
        chk("reset.ctrl_outputs", {26'b0, cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE}, 32'd0);
        chk("reset.data_outputs", PADDR | PWDATA | rsp_rdata | {31'b0, PWRITE}, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset.cmd_ready_held", {31'b0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.cmd_ready_after", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 5; i++) do_xfer($sformatf("vec%0d", i), tbl[i]);

`ifdef CRCU_APB_TIMEOUT_EN
        do_xfer("tmo_expire", mk(1'b0, 32'h0000_0040, 32'h0, -1, 32'h0BAD_F00D, 1'b0, 0,
                                 32'h0000_0040, 32'h0, 32'h0, 1'b1, 1'b1, TMO + 1, TMO + 3));
        do_xfer("tmo_ready_wins", mk(1'b0, 32'h0000_0044, 32'h0, TMO, 32'h0000_1234, 1'b0, 0,
                                     32'h0000_0044, 32'h0, 32'h0000_1234, 1'b0, 1'b0, TMO + 1, TMO + 3));
`else
        do_xfer("long_wait", mk(1'b0, 32'h0000_0040, 32'h0, 12, 32'h0BAD_F00D, 1'b0, 0,
                                32'h0000_0040, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 13, 15));
`endif

        // Reset asserted mid-ACCESS: bus and response must drop without a clock edge.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; PREADY = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.in_access", {30'b0, PSEL, PENABLE}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.async_drop", {29'b0, PSEL, PENABLE, rsp_valid}, 32'd0);
        chk("rst_mid.cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0; PREADY = 1'b1; PRDATA = 32'h7777_7777;
        @(negedge clk);
        chk("rst_mid.cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
        begin
            bit stale = 0;
            for (int i = 0; i < 5; i++) begin
                if (rsp_valid || PSEL) stale = 1;
                @(negedge clk);
            end
            chk("rst_mid.no_stale_rsp", {31'b0, stale}, 32'd0);
        end

        // Reset while a response is pending.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h34; cmd_wdata = 32'h1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp.pending", {31'b0, rsp_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_resp.async_drop", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Three back-to-back writes with cmd_valid and rsp_ready held high.
        b2b_addr[0] = 32'h100; b2b_addr[1] = 32'h204; b2b_addr[2] = 32'h308;
        rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = b2b_addr[0]; cmd_wdata = 32'hB0;
        begin
            int  idx = 0, np = 0;
            bit  pend = 0;
            for (int i = 0; i < 40 && (idx < 3 || np < 3); i++) begin
                if (pend) begin
                    pend = 0;
                    if (idx < 3) begin
                        cmd_addr = b2b_addr[idx]; cmd_wdata = 32'hB0 + idx;
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
                if (PSEL && !PENABLE && np < 3) begin
                    b2b_seen[np] = PADDR; np++;
                end
                if (cmd_valid && cmd_ready && idx < 3) begin
                    b2b_acc[idx] = cyc; idx++; pend = 1;
                end
                @(negedge clk);
            end
            chk("b2b.accepts", idx, 3);
            chk("b2b.setups", np, 3);
        end
        chk("b2b.spacing01", b2b_acc[1] - b2b_acc[0], 4);
        chk("b2b.spacing12", b2b_acc[2] - b2b_acc[1], 4);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b.paddr%0d", i), b2b_seen[i], b2b_addr[i]);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b.drained", {30'b0, rsp_valid, cmd_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
